seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial bit-pattern detector with programmable pattern, selectable overlap mode, valid-qualified input and a saturating match counter. It is the general-purpose successor to the fixed 1011 detector FSM in the serial-protocol front end. It consumes one bit per accepted cycle and emits a registered one-cycle match pulse. It replaces per-pattern hand-coded state machines: any pattern up to PAT_W bits is handled by one instance.

## Interface
- PAT_W, 4: pattern length in bits, 2..32.
- PATTERN, 4'b1011: reset value of the pattern register. Bit PAT_W-1 is the oldest (first-received) bit.
- OVERLAP, 1: 1 allows overlapping matches; 0 clears history after each match.
- CNT_W, 8: width of the match counter, 1..32.

- clk  input  1  rising-edge clock, sole clock.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  in carries a bit this cycle.
- in  input  1  serial data bit.
- pat_load  input  1  load pat_in into the pattern register.
- pat_in  input  PAT_W  new pattern, MSB = first bit.
- count_clr  input  1  clear match_count.
- out  output  1  registered match pulse.
- match_count  output  CNT_W  number of matches since reset/clear, saturating.
- armed  output  1  history holds at least PAT_W valid bits.

## Operation
- State:
  - pattern register pat_q (PAT_W).
  - history shift register hist_q (PAT_W); a newly accepted bit enters the LSB.
  - fill counter fill_q (0..PAT_W), saturating at PAT_W.
  - out, match_count.
- Accept: a bit is accepted on an edge where in_valid=1, pat_load=0 and reset=0.
  - hist_next = {hist_q[PAT_W-2:0], in}.
  - fill_next = min(fill_q+1, PAT_W).
- Match: an accepted bit completes a match when fill_next==PAT_W and hist_next==pat_q.
  - out is 1 for exactly the following cycle.
  - out is 0 in every other cycle.
- Overlap:
  - OVERLAP=1: history is kept after a match. Example: 1011011 gives two matches.
  - OVERLAP=0: on a match, hist_q is set to 0 and fill_q to 0, so the next match needs PAT_W fresh bits.
- Stall: when in_valid=0, hist_q and fill_q hold. out is 0 on the next cycle.
- Pattern load (pat_load=1):
  - pat_q is set to pat_in; hist_q and fill_q are set to 0; out is set to 0.
  - The in_valid bit in the same cycle is discarded.
- Counter: on a match, match_count increments by 1, saturating at 2^CNT_W-1 (it never wraps).
- count_clr:
  - Sets match_count to 0.
  - count_clr has priority: a match on the same edge is not counted, but out still pulses.
  - count_clr has no effect on detection state.
- armed = (fill_q==PAT_W).

## Timing
- Reset values:
  - out=0, match_count=0, armed=0.
  - pat_q=PATTERN, hist_q=0, fill_q=0.
- Reset overrides all other inputs on the same edge. Reset asserted mid-pattern discards partial history; detection restarts from zero bits after deassertion.
- Latency: the completing bit is sampled at edge N; out is high from edge N to edge N+1. Fixed 1-cycle latency.
- match_count updates on the same edge that raises out.
- armed rises on the edge that accepts the PAT_W-th bit.
  - OVERLAP=1: armed stays high until the next reset or pat_load.
  - OVERLAP=0: armed drops on the edge of each match.
- Back-to-back: with OVERLAP=1 and a periodic pattern (e.g. 1111), out may be high on consecutive cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Overlap, default parameters:
  - Stimulus: reset, then in=1,0,1,1,0,1,1 on consecutive valid cycles.
  - Required response: out high in the cycles after bits 4 and 7 only; match_count=2.
- OVERLAP=0, same stream:
  - Required response: out high only after bit 4; match_count=1; armed drops at the match.
- Valid gaps:
  - Stimulus: 1011 with in_valid=0 for 3 cycles between each bit (in toggling during gaps).
  - Required response: single out pulse after the 4th valid bit; no pulse during the gaps.
- Runtime pattern change:
  - Stimulus: after bits 1,0,1, assert pat_load with pat_in=4'b0110 and in_valid=1, in=1; then send 0,1,1,0.
  - Required response: no match on the old pattern; out pulses after the final 0; match_count=1.
- Saturation and clear priority, CNT_W=2:
  - Stimulus: 5 matches, then count_clr coincident with a 6th match.
  - Required response: match_count reads 3 after the 4th and 5th matches; reads 0 after the 6th; out still pulses for the 6th.
- Reset mid-operation:
  - Stimulus: after bits 1,0,1, assert reset for 1 cycle; then send 1,0,1,1.
  - Required response: no pulse from the pre-reset bits; exactly one pulse after the 4th post-reset bit; all outputs 0 during reset.

Source files
------------

// File: rtl/seq_detector_param_if.sv
// Serial detector bus: one data bit per valid cycle, pattern load/clear controls in,
// registered match pulse, saturating match count and armed flag out.
interface seq_detector_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             count_clr;
    logic             out;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    modport master (
        output in_valid, in, pat_load, pat_in, count_clr,
        input  out, match_count, armed
    );

    modport slave (
        input  in_valid, in, pat_load, pat_in, count_clr,
        output out, match_count, armed
    );
endinterface

// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector with overlap select and saturating match counter.
// One-cycle registered match pulse; no backpressure, a bit is taken whenever in_valid is high.
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input logic                 clk,
    input logic                 reset,
    seq_detector_param_if.slave bus
);
    localparam int              FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  hist_q;
    logic [PAT_W-1:0]  hist_next;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_next;
    logic [CNT_W-1:0]  cnt_q;
    logic              out_q;
    logic              accept;
    logic              match;

    // A bit arriving alongside a pattern load is dropped.
    assign accept    = bus.in_valid && !bus.pat_load;
    assign hist_next = {hist_q[PAT_W-2:0], bus.in};
    assign fill_next = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    assign match     = accept && (fill_next == FILL_FULL) && (hist_next == pat_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else if (bus.pat_load) begin
            pat_q  <= bus.pat_in;
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            out_q <= match;
            if (accept) begin
                if (match && !OVERLAP) begin
                    hist_q <= '0;
                    fill_q <= '0;
                end else begin
                    hist_q <= hist_next;
                    fill_q <= fill_next;
                end
            end
        end
    end

    // Clear wins over a coincident match; detection state is untouched by it.
    always_ff @(posedge clk) begin
        if (reset || bus.count_clr) begin
            cnt_q <= '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.out         = out_q;
    assign bus.match_count = cnt_q;
    assign bus.armed       = (fill_q == FILL_FULL);
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: three instances (overlap, no-overlap, 2-bit counter)
// share one stimulus stream; each scenario task checks the instance it targets.
module tb_seq_detector_param;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_bit;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       count_clr;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) bus_ov ();
    seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) bus_nov ();
    seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) bus_sat ();

    assign bus_ov.in_valid   = in_valid;
    assign bus_ov.in         = in_bit;
    assign bus_ov.pat_load   = pat_load;
    assign bus_ov.pat_in     = pat_in;
    assign bus_ov.count_clr  = count_clr;
    assign bus_nov.in_valid  = in_valid;
    assign bus_nov.in        = in_bit;
    assign bus_nov.pat_load  = pat_load;
    assign bus_nov.pat_in    = pat_in;
    assign bus_nov.count_clr = count_clr;
    assign bus_sat.in_valid  = in_valid;
    assign bus_sat.in        = in_bit;
    assign bus_sat.pat_load  = pat_load;
    assign bus_sat.pat_in    = pat_in;
    assign bus_sat.count_clr = count_clr;

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .clk(clk), .reset(reset), .bus(bus_ov.slave));
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_nov (
        .clk(clk), .reset(reset), .bus(bus_nov.slave));
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(bus_sat.slave));

    task automatic step(input logic v, input logic b, input logic clr);
        @(negedge clk);
        reset = 1'b0; pat_load = 1'b0;
        in_valid = v; in_bit = b; count_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic v, input logic b);
        @(negedge clk);
        reset = 1'b1; pat_load = 1'b0; count_clr = 1'b0;
        in_valid = v; in_bit = b;
        @(posedge clk);
        #1;
    endtask

    task automatic load_pattern(input logic [3:0] p, input logic v, input logic b);
        @(negedge clk);
        reset = 1'b0; pat_load = 1'b1; pat_in = p; count_clr = 1'b0;
        in_valid = v; in_bit = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset(1'b0, 1'b0);
        apply_reset(1'b1, 1'b1);
        n_vec++; if (bus_ov.out !== 1'b0)          begin n_err++; $display("FAIL reset_ov_out: got %b expected 0", bus_ov.out); end
        n_vec++; if (bus_ov.match_count !== 8'd0)  begin n_err++; $display("FAIL reset_ov_count: got %0d expected 0", bus_ov.match_count); end
        n_vec++; if (bus_ov.armed !== 1'b0)        begin n_err++; $display("FAIL reset_ov_armed: got %b expected 0", bus_ov.armed); end
        n_vec++; if (bus_nov.out !== 1'b0)         begin n_err++; $display("FAIL reset_nov_out: got %b expected 0", bus_nov.out); end
        n_vec++; if (bus_nov.match_count !== 8'd0) begin n_err++; $display("FAIL reset_nov_count: got %0d expected 0", bus_nov.match_count); end
        n_vec++; if (bus_sat.match_count !== 2'd0) begin n_err++; $display("FAIL reset_sat_count: got %0d expected 0", bus_sat.match_count); end
    endtask

    // 1011011: two matches with overlap, one without.
    task automatic test_overlap();
        logic [6:0] bits      = 7'b1011011;
        logic [6:0] exp_ov    = 7'b0001001;
        logic [6:0] exp_arm   = 7'b0001111;
        logic [6:0] exp_nov   = 7'b0001000;
        apply_reset(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[6-i], 1'b0);
            n_vec++; if (bus_ov.out !== exp_ov[6-i])    begin n_err++; $display("FAIL overlap_ov_out[%0d]: got %b expected %b", i, bus_ov.out, exp_ov[6-i]); end
            n_vec++; if (bus_ov.armed !== exp_arm[6-i]) begin n_err++; $display("FAIL overlap_ov_armed[%0d]: got %b expected %b", i, bus_ov.armed, exp_arm[6-i]); end
            n_vec++; if (bus_nov.out !== exp_nov[6-i])  begin n_err++; $display("FAIL overlap_nov_out[%0d]: got %b expected %b", i, bus_nov.out, exp_nov[6-i]); end
            n_vec++; if (bus_nov.armed !== 1'b0)        begin n_err++; $display("FAIL overlap_nov_armed[%0d]: got %b expected 0", i, bus_nov.armed); end
        end
        n_vec++; if (bus_ov.match_count !== 8'd2)  begin n_err++; $display("FAIL overlap_ov_count: got %0d expected 2", bus_ov.match_count); end
        n_vec++; if (bus_nov.match_count !== 8'd1) begin n_err++; $display("FAIL overlap_nov_count: got %0d expected 1", bus_nov.match_count); end
    endtask

    // 01011011: no-overlap instance arms on bit 4, matches on bit 5 and disarms, then needs 4 fresh bits.
    task automatic test_no_overlap();
        logic [7:0] bits    = 8'b01011011;
        logic [7:0] exp_out = 8'b00001000;
        logic [7:0] exp_arm = 8'b00010000;
        apply_reset(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, bits[7-i], 1'b0);
            n_vec++; if (bus_nov.out !== exp_out[7-i])   begin n_err++; $display("FAIL nov_out[%0d]: got %b expected %b", i, bus_nov.out, exp_out[7-i]); end
            n_vec++; if (bus_nov.armed !== exp_arm[7-i]) begin n_err++; $display("FAIL nov_armed[%0d]: got %b expected %b", i, bus_nov.armed, exp_arm[7-i]); end
        end
        n_vec++; if (bus_nov.match_count !== 8'd1) begin n_err++; $display("FAIL nov_count: got %0d expected 1", bus_nov.match_count); end
        n_vec++; if (bus_ov.match_count !== 8'd2)  begin n_err++; $display("FAIL nov_ov_count: got %0d expected 2", bus_ov.match_count); end
    endtask

    task automatic test_valid_gaps();
        logic [3:0] bits = 4'b1011;
        apply_reset(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bits[3-i], 1'b0);
            n_vec++; if (bus_ov.out !== (i == 3)) begin n_err++; $display("FAIL gap_bit_out[%0d]: got %b expected %b", i, bus_ov.out, (i == 3)); end
            for (int g = 0; g < 3; g++) begin
                step(1'b0, g[0], 1'b0);
                n_vec++; if (bus_ov.out !== 1'b0) begin n_err++; $display("FAIL gap_idle_out[%0d.%0d]: got %b expected 0", i, g, bus_ov.out); end
            end
        end
        n_vec++; if (bus_ov.match_count !== 8'd1) begin n_err++; $display("FAIL gap_count: got %0d expected 1", bus_ov.match_count); end
    endtask

    task automatic test_pattern_load();
        logic [2:0] pre     = 3'b101;
        logic [3:0] post    = 4'b0110;
        logic [3:0] exp_out = 4'b0001;
        apply_reset(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, pre[2-i], 1'b0);
        load_pattern(4'b0110, 1'b1, 1'b1);
        n_vec++; if (bus_ov.out !== 1'b0)   begin n_err++; $display("FAIL load_out: got %b expected 0", bus_ov.out); end
        n_vec++; if (bus_ov.armed !== 1'b0) begin n_err++; $display("FAIL load_armed: got %b expected 0", bus_ov.armed); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, post[3-i], 1'b0);
            n_vec++; if (bus_ov.out !== exp_out[3-i]) begin n_err++; $display("FAIL load_post_out[%0d]: got %b expected %b", i, bus_ov.out, exp_out[3-i]); end
        end
        n_vec++; if (bus_ov.match_count !== 8'd1) begin n_err++; $display("FAIL load_count: got %0d expected 1", bus_ov.match_count); end
    endtask

    // 1011 then 011 x4 gives matches at bits 3,6,9,12,15 on the 2-bit counter instance.
    task automatic test_saturation();
        logic [15:0] bits = 16'b1011011011011011;
        int          k    = 0;
        logic        m;
        apply_reset(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, bits[15-i], 1'b0);
            m = (i >= 3) && ((i % 3) == 0);
            n_vec++; if (bus_sat.out !== m) begin n_err++; $display("FAIL sat_out[%0d]: got %b expected %b", i, bus_sat.out, m); end
            if (m) begin
                k++;
                n_vec++;
                if (bus_sat.match_count !== 2'((k > 3) ? 3 : k)) begin
                    n_err++; $display("FAIL sat_count[match %0d]: got %0d expected %0d", k, bus_sat.match_count, (k > 3) ? 3 : k);
                end
            end
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        n_vec++; if (bus_sat.out !== 1'b1)         begin n_err++; $display("FAIL clr_out: got %b expected 1", bus_sat.out); end
        n_vec++; if (bus_sat.match_count !== 2'd0) begin n_err++; $display("FAIL clr_count: got %0d expected 0", bus_sat.match_count); end
        n_vec++; if (bus_sat.armed !== 1'b1)       begin n_err++; $display("FAIL clr_armed: got %b expected 1", bus_sat.armed); end
        step(1'b0, 1'b0, 1'b0);
        n_vec++; if (bus_sat.out !== 1'b0)         begin n_err++; $display("FAIL clr_after_out: got %b expected 0", bus_sat.out); end
    endtask

    task automatic test_reset_mid();
        logic [5:0] pre     = 6'b101101;
        logic [3:0] post    = 4'b1011;
        logic [3:0] exp_out = 4'b0001;
        apply_reset(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, pre[5-i], 1'b0);
        // Without the reset this bit would complete 1011011.
        apply_reset(1'b1, 1'b1);
        n_vec++; if (bus_ov.out !== 1'b0)         begin n_err++; $display("FAIL rmid_out: got %b expected 0", bus_ov.out); end
        n_vec++; if (bus_ov.match_count !== 8'd0) begin n_err++; $display("FAIL rmid_count: got %0d expected 0", bus_ov.match_count); end
        n_vec++; if (bus_ov.armed !== 1'b0)       begin n_err++; $display("FAIL rmid_armed: got %b expected 0", bus_ov.armed); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, post[3-i], 1'b0);
            n_vec++; if (bus_ov.out !== exp_out[3-i]) begin n_err++; $display("FAIL rmid_post_out[%0d]: got %b expected %b", i, bus_ov.out, exp_out[3-i]); end
        end
        n_vec++; if (bus_ov.match_count !== 8'd1) begin n_err++; $display("FAIL rmid_post_count: got %0d expected 1", bus_ov.match_count); end
    endtask

    // Pattern 1111 on a run of ones: consecutive pulses with overlap, single pulse without.
    task automatic test_back_to_back();
        logic [5:0] exp_ov  = 6'b000111;
        logic [5:0] exp_nov = 6'b000100;
        apply_reset(1'b0, 1'b0);
        load_pattern(4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0);
            n_vec++; if (bus_ov.out !== exp_ov[5-i])   begin n_err++; $display("FAIL b2b_ov_out[%0d]: got %b expected %b", i, bus_ov.out, exp_ov[5-i]); end
            n_vec++; if (bus_nov.out !== exp_nov[5-i]) begin n_err++; $display("FAIL b2b_nov_out[%0d]: got %b expected %b", i, bus_nov.out, exp_nov[5-i]); end
        end
        n_vec++; if (bus_ov.match_count !== 8'd3)  begin n_err++; $display("FAIL b2b_ov_count: got %0d expected 3", bus_ov.match_count); end
        n_vec++; if (bus_nov.match_count !== 8'd1) begin n_err++; $display("FAIL b2b_nov_count: got %0d expected 1", bus_nov.match_count); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
        pat_load = 1'b0; pat_in = 4'b0000; count_clr = 1'b0;
        test_reset();
        test_overlap();
        test_no_overlap();
        test_valid_gaps();
        test_pattern_load();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
